// File: rtl/psm_pkg.sv
// Shared definitions for the PSM arbiter slice.
// State encoding, PSM data width and requester ID width.
package psm_pkg;

   localparam int DW  = 8;
   localparam int IDW = 3;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LAUNCH    = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_RUN       = 3'd3,
      S_DONE      = 3'd4
   } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector.
// Ports: req (levels), ptr (search start) -> gnt (one-hot), idx.
import psm_pkg::*;

module rr_picker #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [PW-1:0]  ptr,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] idx
);

   logic found;
   int   j;

   // Walk from ptr upward, wrapping; first asserted request wins.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!found && req[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = IDW'(j);
         end
      end
   end

endmodule

// File: rtl/psm_arbiter.sv
// Round-robin arbiter/sequencer sharing one PSM among requesters.
// Ports: Req/ReqDin* in, Grant/Done/DoneId/ResOp*/Timeout/Busy out, Psm* link.
import psm_pkg::*;

module psm_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int START_TIMEOUT = 16
) (
   input  logic                  Clock,
   input  logic                  ResetN,
   input  logic [NUM_REQ-1:0]    Req,
   input  logic [DW*NUM_REQ-1:0] ReqDin1,
   input  logic [DW*NUM_REQ-1:0] ReqDin2,
   output logic [NUM_REQ-1:0]    Grant,
   output logic                  Done,
   output logic [IDW-1:0]        DoneId,
   output logic [DW-1:0]         ResOp1,
   output logic [DW-1:0]         ResOp2,
   output logic [DW-1:0]         ResOp3,
   output logic                  Timeout,
   output logic                  Busy,
   output logic                  PsmStart,
   output logic [DW-1:0]         PsmDin1,
   output logic [DW-1:0]         PsmDin2,
   input  logic                  PsmReady,
   input  logic                  PsmOp1,
   input  logic                  PsmOp2,
   input  logic                  PsmOp3,
   input  logic [DW-1:0]         PsmDout
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(START_TIMEOUT + 1);

   state_t           state, nxt;
   logic [PW-1:0]    ptr, ptr_nx;
   logic [IDW-1:0]   cur_id, done_id;
   logic [DW-1:0]    din1, din2;
   logic [DW-1:0]    r1, r2, r3;
   logic [DW-1:0]    sel1, sel2;
   logic [CW-1:0]    cnt, cnt_nx;
   logic             tflag, accept, expired;
   logic [NUM_REQ-1:0] pick;
   logic [IDW-1:0]   pick_idx;

   rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick (
      .req (Req),
      .ptr (ptr),
      .gnt (pick),
      .idx (pick_idx)
   );

   assign accept  = (state == S_IDLE) && (|Req) && PsmReady;
   assign cnt_nx  = cnt + 1'b1;
   assign expired = (cnt_nx == CW'(START_TIMEOUT));

   always_comb begin
      sel1 = '0;
      sel2 = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[i]) begin
            sel1 = sel1 | ReqDin1[i*DW +: DW];
            sel2 = sel2 | ReqDin2[i*DW +: DW];
         end
      end
   end

   always_comb begin
      ptr_nx = '0;
      if (int'(pick_idx) < NUM_REQ - 1)
         ptr_nx = PW'(int'(pick_idx) + 1);
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE:      if (accept) nxt = S_LAUNCH;
         S_LAUNCH:    nxt = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            if (!PsmReady)   nxt = S_RUN;
            else if (expired) nxt = S_DONE;
         end
         S_RUN:       if (PsmReady) nxt = S_DONE;
         S_DONE:      nxt = S_IDLE;
         default:     nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state   <= S_IDLE;
         ptr     <= '0;
         cur_id  <= '0;
         done_id <= '0;
         din1    <= '0;
         din2    <= '0;
         r1      <= '0;
         r2      <= '0;
         r3      <= '0;
         cnt     <= '0;
         tflag   <= 1'b0;
      end else begin
         state <= nxt;
         if (accept) begin
            ptr    <= ptr_nx;
            cur_id <= pick_idx;
            din1   <= sel1;
            din2   <= sel2;
         end
         if (state == S_LAUNCH) begin
            cnt   <= '0;
            tflag <= 1'b0;
            r1    <= '0;
            r2    <= '0;
            r3    <= '0;
         end
         if (state == S_WAIT_BUSY) begin
            cnt <= cnt_nx;
            if (PsmReady && expired) tflag <= 1'b1;
         end
         if (state == S_RUN) begin
            if (PsmOp1) r1 <= PsmDout;
            if (PsmOp2) r2 <= PsmDout;
            if (PsmOp3) r3 <= PsmDout;
         end
         // ID is frozen on entry to DONE so it survives the next Grant.
         if (nxt == S_DONE) done_id <= cur_id;
      end
   end

   // Grant is combinational; gate it so reset forces it low.
   assign Grant    = (accept && ResetN) ? pick : '0;
   assign PsmStart = (state == S_LAUNCH);
   assign Busy     = (state != S_IDLE);
   assign Done     = (state == S_DONE);
   assign Timeout  = (state == S_DONE) && tflag;
   assign DoneId   = done_id;
   assign ResOp1   = r1;
   assign ResOp2   = r2;
   assign ResOp3   = r3;
   assign PsmDin1  = din1;
   assign PsmDin2  = din2;

endmodule

// File: tb/tb_psm_arbiter.sv
// Randomized self-checking bench for psm_arbiter.
// Includes a behavioural PSM and a round-robin reference model.
module tb_psm_arbiter;
   import psm_pkg::*;

   localparam int N  = 4;
   localparam int ST = 16;

   logic            Clock = 1'b0;
   logic            ResetN = 1'b0;
   logic [N-1:0]    Req;
   logic [8*N-1:0]  ReqDin1, ReqDin2;
   logic [N-1:0]    Grant;
   logic            Done, Timeout, Busy, PsmStart;
   logic [2:0]      DoneId;
   logic [7:0]      ResOp1, ResOp2, ResOp3;
   logic [7:0]      PsmDin1, PsmDin2, PsmDout;
   logic            PsmReady, PsmOp1, PsmOp2, PsmOp3;

   always #5 Clock = ~Clock;

   psm_arbiter #(.NUM_REQ(N), .START_TIMEOUT(ST)) dut (
      .Clock(Clock), .ResetN(ResetN), .Req(Req),
      .ReqDin1(ReqDin1), .ReqDin2(ReqDin2), .Grant(Grant),
      .Done(Done), .DoneId(DoneId), .ResOp1(ResOp1),
      .ResOp2(ResOp2), .ResOp3(ResOp3), .Timeout(Timeout),
      .Busy(Busy), .PsmStart(PsmStart), .PsmDin1(PsmDin1),
      .PsmDin2(PsmDin2), .PsmReady(PsmReady), .PsmOp1(PsmOp1),
      .PsmOp2(PsmOp2), .PsmOp3(PsmOp3), .PsmDout(PsmDout)
   );

   // ---- behavioural PSM ----
   logic       psm_stuck;
   int         len1, len2, len3;
   logic [7:0] pa, pb;
   int         phase, pcnt;

   function automatic logic [7:0] psm_f(int p, logic [7:0] a, logic [7:0] b);
      if (p == 1) return a | b;
      if (p == 2) return a ^ b;
      return a & ~b;
   endfunction

   function automatic int plen(int p);
      if (p == 1) return len1;
      if (p == 2) return len2;
      return len3;
   endfunction

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         phase <= 0; pcnt <= 0; pa <= '0; pb <= '0;
      end else if (phase == 0) begin
         if (PsmStart && !psm_stuck) begin
            pa <= PsmDin1; pb <= PsmDin2; phase <= 1; pcnt <= 0;
         end
      end else if (pcnt == plen(phase) - 1) begin
         phase <= (phase == 3) ? 0 : phase + 1;
         pcnt  <= 0;
      end else begin
         pcnt <= pcnt + 1;
      end
   end

   assign PsmReady = (phase == 0);
   assign PsmOp1   = (phase == 1);
   assign PsmOp2   = (phase == 2);
   assign PsmOp3   = (phase == 3);
   // First cycle of a phase shows a decoy so "last value" is really tested.
   assign PsmDout  = (phase == 0) ? 8'hA5 :
                     (pcnt == 0) ? ~psm_f(phase, pa, pb) : psm_f(phase, pa, pb);

   // ---- checking ----
   int checks = 0, failures = 0;
   int ref_ptr = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge Clock);
      #1;
   endtask

   function automatic int rr_win(logic [N-1:0] m);
      for (int k = 0; k < N; k++)
         if (m[(ref_ptr + k) % N]) return (ref_ptr + k) % N;
      return -1;
   endfunction

   task automatic rand_ops();
      for (int i = 0; i < N; i++) begin
         ReqDin1[8*i +: 8] = 8'($urandom);
         ReqDin2[8*i +: 8] = 8'($urandom);
      end
   endtask

   task automatic do_job(input logic [N-1:0] mask, input bit drop,
                         input bit exp_to, input logic [N-1:0] raise);
      logic [7:0]   a, b;
      logic [N-1:0] oh;
      int  w, lat, elat;
      bit  got, busy_ok, ng_ok, din_ok;
      Req = mask;
      #1;
      got = 0;
      for (int c = 0; c < 100; c++) begin
         if (Grant != '0) begin got = 1; break; end
         tick();
      end
      chk("grant_seen", got, 1);
      if (!got) return;
      w = rr_win(Req);
      oh = '0;
      oh[w] = 1'b1;
      chk("grant", Grant, oh);
      a = ReqDin1[8*w +: 8];
      b = ReqDin2[8*w +: 8];
      ref_ptr = (w + 1) % N;
      tick();
      chk("start", PsmStart, 1);
      chk("din1", PsmDin1, a);
      chk("din2", PsmDin2, b);
      if (drop) Req = '0;
      lat = 1; got = 0; busy_ok = 1; ng_ok = 1; din_ok = 1;
      for (int c = 0; c < 200; c++) begin
         if (Done) begin got = 1; break; end
         if (!Busy) busy_ok = 0;
         if (Grant != '0 || Timeout) ng_ok = 0;
         if (PsmDin1 !== a || PsmDin2 !== b) din_ok = 0;
         if (c == 3 && raise != '0) Req = Req | raise;
         tick();
         lat++;
      end
      chk("done_seen", got, 1);
      if (!got) return;
      elat = exp_to ? ST + 2 : len1 + len2 + len3 + 3;
      chk("latency", lat, elat);
      chk("done_id", DoneId, w);
      chk("res1", ResOp1, exp_to ? 8'h00 : psm_f(1, a, b));
      chk("res2", ResOp2, exp_to ? 8'h00 : psm_f(2, a, b));
      chk("res3", ResOp3, exp_to ? 8'h00 : psm_f(3, a, b));
      chk("timeout", Timeout, exp_to);
      chk("busy_job", busy_ok, 1);
      chk("no_grant_job", ng_ok, 1);
      chk("din_stable", din_ok, 1);
      tick();
      chk("done_pulse", Done, 0);
      chk("idle", Busy, 0);
   endtask

   task automatic chk_zero(input string tag);
      chk(tag, {Grant, Done, DoneId, ResOp1, ResOp2, ResOp3,
                Timeout, Busy, PsmStart, PsmDin1, PsmDin2}, 0);
   endtask

   initial begin
      bit nodone;
      Req = '0; ReqDin1 = '0; ReqDin2 = '0;
      psm_stuck = 0; len1 = 10; len2 = 7; len3 = 5;
      #2 Req = '1;
      #1 chk_zero("reset_outs");
      Req = '0;
      tick(); tick();
      ResetN = 1'b1;
      tick();

      // single request on requester 2
      ReqDin1[23:16] = 8'h0F;
      ReqDin2[23:16] = 8'hF0;
      do_job(4'b0100, 1, 0, '0);
      chk("single_res1", ResOp1, 8'hFF);
      chk("single_res3", ResOp3, 8'h0F);

      // wrap-around from pointer 3, then pointer must be 1
      rand_ops();
      len1 = 3; len2 = 2; len3 = 4;
      do_job(4'b0011, 1, 0, '0);
      chk("wrap_id", DoneId, 0);
      do_job(4'b1111, 1, 0, '0);
      chk("ptr_after_wrap", DoneId, 1);
      do_job(4'b1000, 1, 0, '0);

      // fairness with all requests held high
      for (int j = 0; j < 8; j++) begin
         len1 = $urandom_range(2, 5);
         len2 = $urandom_range(2, 5);
         len3 = $urandom_range(2, 5);
         do_job(4'b1111, 0, 0, '0);
         chk("fair_order", DoneId, j % N);
      end
      Req = '0;
      tick();

      // start timeout
      psm_stuck = 1;
      rand_ops();
      do_job(4'($urandom_range(1, 15)), 1, 1, '0);
      psm_stuck = 0;

      // Req[1] raised mid-job, operands changed before its grant
      len1 = 6; len2 = 6; len3 = 6;
      rand_ops();
      do_job(4'b0001, 1, 0, 4'b0010);
      ReqDin1[15:8] = 8'h3C;
      ReqDin2[15:8] = 8'h5A;
      do_job(4'b0010, 1, 0, '0);
      chk("mid_res2", ResOp2, 8'h66);

      // randomized jobs
      for (int j = 0; j < 20; j++) begin
         len1 = $urandom_range(2, 8);
         len2 = $urandom_range(2, 8);
         len3 = $urandom_range(2, 8);
         rand_ops();
         do_job(4'($urandom_range(1, 15)), 1, 0, '0);
      end

      // reset during RUN
      len1 = 5; len2 = 5; len3 = 5;
      do_job(4'b0110, 1, 0, '0);
      Req = 4'b0010;
      #1;
      for (int c = 0; c < 20 && Grant == '0; c++) tick();
      ref_ptr = 2;
      for (int c = 0; c < 5; c++) tick();
      Req = '1;
      ResetN = 1'b0;
      #1 chk_zero("reset_mid");
      nodone = 1;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (Done || Busy) nodone = 0;
      end
      chk("reset_quiet", nodone, 1);
      Req = '0;
      ResetN = 1'b1;
      ref_ptr = 0;
      tick();
      rand_ops();
      do_job(4'b1111, 1, 0, '0);
      chk("ptr_after_reset", DoneId, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
